req_pacer: RTL and testbench



---
 rtl/req_pacer_pkg.sv | 14 +
 rtl/req_pacer_if.sv | 26 ++
 rtl/req_pacer_tmr.sv | 28 ++
 rtl/req_pacer.sv | 115 +++++++++++
 tb/tb_req_pacer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/req_pacer_pkg.sv
// Shared definitions for the request pacer: state encoding and default timeout.
`timescale 1ns/1ps
package req_pacer_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ISSUE = 2'd1;
   localparam state_t WAIT  = 2'd2;
   localparam state_t GAP   = 2'd3;

   localparam int TMO_VAL_DEF = 64;

endpackage

// File: rtl/req_pacer_if.sv
// Event/request handshake bundle between the pacer and its neighbours.
`timescale 1ns/1ps
interface req_pacer_if #(
   parameter int CNT_W = 4
);

   logic             ev_in;
   logic             ack_in;
   logic             clr_ovf;
   logic             req_out;
   logic [CNT_W-1:0] pending;
   logic             busy;
   logic             ovf;
   logic             tmo;

   modport master (
      output ev_in, ack_in, clr_ovf,
      input  req_out, pending, busy, ovf, tmo
   );

   modport slave (
      input  ev_in, ack_in, clr_ovf,
      output req_out, pending, busy, ovf, tmo
   );

endinterface

// File: rtl/req_pacer_tmr.sv
// Loadable down-counter that stops at zero; times out an unacknowledged request.
`timescale 1ns/1ps
module req_pacer_tmr #(
   parameter int TMO_W = 8
) (
   input  logic             in_clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMO_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [TMO_W-1:0] cnt;

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/req_pacer.sv
// Counts event pulses and releases them one at a time as req_out pulses, paced by ack_in or timeout.
// Build option REQ_PACER_COALESCE_EN: one req_out stands for every event pending at issue time.
`timescale 1ns/1ps
module req_pacer
   import req_pacer_pkg::*;
#(
   parameter int CNT_W   = 4,
   parameter int TMO_W   = 8,
   parameter int TMO_VAL = TMO_VAL_DEF
) (
   input logic         rst,
   input logic         in_clk,
   req_pacer_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_VAL - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] pend_q;
   logic             inc;
   logic             dec;
   logic             sat;
   logic             tmr_load;
   logic             tmr_dec;
   logic             tmr_zero;
   logic             req_d, busy_d, tmo_d, ovf_d;
   logic             req_q, busy_q, tmo_q, ovf_q;

   assign inc = bus.ev_in;
   assign dec = (state == IDLE) && (pend_q != '0);
   assign sat = inc && !dec && (pend_q == CNT_MAX);

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pend_q != '0) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (bus.ack_in || tmr_zero) state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // An ack arriving on the same cycle the timer hits zero wins over the timeout.
   always_comb begin
      req_d    = (state_nxt == ISSUE);
      busy_d   = (state_nxt != IDLE);
      tmo_d    = (state == WAIT) && !bus.ack_in && tmr_zero;
      tmr_load = (state == ISSUE);
      tmr_dec  = (state == WAIT) && !bus.ack_in;
      ovf_d    = sat || (ovf_q && !bus.clr_ovf);
   end

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         req_q  <= 1'b0;
         busy_q <= 1'b0;
         tmo_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         req_q  <= req_d;
         busy_q <= busy_d;
         tmo_q  <= tmo_d;
         ovf_q  <= ovf_d;
      end
   end

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         pend_q <= '0;
      end else begin
`ifdef REQ_PACER_COALESCE_EN
         if (dec) begin
            pend_q <= {{(CNT_W-1){1'b0}}, inc};
         end else if (inc && (pend_q != CNT_MAX)) begin
            pend_q <= pend_q + 1'b1;
         end
`else
         if (inc && !dec && (pend_q != CNT_MAX)) begin
            pend_q <= pend_q + 1'b1;
         end else if (dec && !inc) begin
            pend_q <= pend_q - 1'b1;
         end
`endif
      end
   end

   req_pacer_tmr #(
      .TMO_W (TMO_W)
   ) u_tmr (
      .in_clk   (in_clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (TMO_LOAD),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   assign bus.req_out = req_q;
   assign bus.busy    = busy_q;
   assign bus.tmo     = tmo_q;
   assign bus.ovf     = ovf_q;
   assign bus.pending = pend_q;

endmodule

// File: tb/tb_req_pacer.sv
// Directed bench for req_pacer (CNT_W=4, TMO_VAL=64); expectations are hand-derived cycle counts.
`timescale 1ns/1ps
module tb_req_pacer;

   localparam int CNT_W = 4;

   logic rst;
   logic in_clk;
   int   n_chk  = 0;
   int   n_pass = 0;

   req_pacer_if #(.CNT_W(CNT_W)) bus ();

   req_pacer #(
      .CNT_W   (CNT_W),
      .TMO_W   (8),
      .TMO_VAL (64)
   ) dut (
      .rst    (rst),
      .in_clk (in_clk),
      .bus    (bus)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic tick;
      @(posedge in_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic do_reset;
      rst         = 1'b0;
      bus.ev_in   = 1'b0;
      bus.ack_in  = 1'b0;
      bus.clr_ovf = 1'b0;
      tick;
      tick;
      rst = 1'b1;
   endtask

   initial begin
      int last_req, nreq, ack_at, tmo_cnt, first_req, ntmo, cnt;
      int req_t[3];
      int tmo_t[2];

      // Reset values
      do_reset;
      chk("rst_req_out", 32'(bus.req_out), 0);
      chk("rst_busy",    32'(bus.busy),    0);
      chk("rst_ovf",     32'(bus.ovf),     0);
      chk("rst_tmo",     32'(bus.tmo),     0);
      chk("rst_pending", 32'(bus.pending), 0);

      // Three events, each req_out acked 5 cycles later
      last_req = -100; nreq = 0; ack_at = -1; tmo_cnt = 0; first_req = -1;
      for (int t = 1; t <= 40; t++) begin
         bus.ev_in  = (t == 1) || (t == 3) || (t == 5);
         bus.ack_in = (t == ack_at);
         tick;
         if (t == 1) chk("s1_pend_after_ev", 32'(bus.pending), 1);
         if (t == 5) chk("s1_pend_peak", 32'(bus.pending), 2);
         if (bus.req_out) begin
            if (nreq == 0) first_req = t;
            else chk("s1_req_spacing_ge4", 32'(t - last_req >= 4), 1);
            last_req = t;
            nreq++;
            ack_at = t + 5;
         end
         if (bus.tmo) tmo_cnt++;
      end
      chk("s1_first_req_edge", 32'(first_req), 2);
      chk("s1_req_count",      32'(nreq),      3);
      chk("s1_tmo_count",      32'(tmo_cnt),   0);
      chk("s1_pend_final",     32'(bus.pending), 0);
      chk("s1_busy_final",     32'(bus.busy),    0);

      // Saturation, ovf priority over clr_ovf, and timeouts with no ack
      nreq = 0; ntmo = 0; tmo_cnt = 0;
      for (int t = 1; t <= 140; t++) begin
         bus.ev_in   = (t <= 21);
         bus.clr_ovf = (t == 21) || (t == 22);
         bus.ack_in  = 1'b0;
         tick;
         if (t == 2) chk("s2_pend_inc_dec", 32'(bus.pending), 1);
         if (t == 16) begin
            chk("s2_pend_reach_max", 32'(bus.pending), 15);
            chk("s2_ovf_before_sat", 32'(bus.ovf), 0);
         end
         if (t == 17) chk("s2_ovf_set", 32'(bus.ovf), 1);
         if (t == 20) chk("s2_pend_sat", 32'(bus.pending), 15);
         if (t == 21) chk("s2_ovf_set_beats_clr", 32'(bus.ovf), 1);
         if (t == 22) chk("s2_ovf_cleared", 32'(bus.ovf), 0);
         if (t == 69) chk("s2_pend_after_reissue", 32'(bus.pending), 14);
         if (bus.req_out) begin
            if (nreq < 3) req_t[nreq] = t;
            nreq++;
         end
         if (bus.tmo) begin
            if (ntmo < 2) tmo_t[ntmo] = t;
            ntmo++;
         end
      end
      chk("s2_req_count", 32'(nreq), 3);
      chk("s2_tmo_count", 32'(ntmo), 2);
      if (nreq >= 3) begin
         chk("s2_req0_edge", 32'(req_t[0]), 2);
         chk("s2_req1_edge", 32'(req_t[1]), 69);
         chk("s2_req2_edge", 32'(req_t[2]), 136);
      end
      if (ntmo >= 2) begin
         chk("s2_tmo0_edge", 32'(tmo_t[0]), 67);
         chk("s2_tmo1_edge", 32'(tmo_t[1]), 134);
      end

      do_reset;
      chk("s3_reset_pend", 32'(bus.pending), 0);
      chk("s3_reset_ovf",  32'(bus.ovf),     0);

      // ack_in while IDLE and while in GAP
      bus.ack_in = 1'b1;
      tick;
      chk("s4_ack_idle_busy", 32'(bus.busy),    0);
      chk("s4_ack_idle_req",  32'(bus.req_out), 0);
      bus.ack_in = 1'b0;
      bus.ev_in = 1'b1; tick;
      bus.ev_in = 1'b0; tick;
      chk("s4_req", 32'(bus.req_out), 1);
      tick;
      chk("s4_wait_busy", 32'(bus.busy), 1);
      bus.ack_in = 1'b1; tick;
      chk("s4_gap_busy", 32'(bus.busy), 1);
      bus.ack_in = 1'b1; tick;
      chk("s4_ack_gap_idle", 32'(bus.busy), 0);
      bus.ack_in = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (bus.req_out) cnt++;
      end
      chk("s4_no_extra_req", 32'(cnt), 0);

      // ack_in on the cycle the timer reaches zero
      bus.ev_in = 1'b1; tick;
      bus.ev_in = 1'b0; tick;
      chk("s4b_req", 32'(bus.req_out), 1);
      repeat (64) tick;
      chk("s4b_pre_tmo", 32'(bus.tmo),  0);
      chk("s4b_pre_busy", 32'(bus.busy), 1);
      bus.ack_in = 1'b1; tick;
      bus.ack_in = 1'b0;
      chk("s4b_ack_at_zero_tmo", 32'(bus.tmo),  0);
      chk("s4b_gap_busy",        32'(bus.busy), 1);
      tick;
      chk("s4b_idle_busy", 32'(bus.busy), 0);
      chk("s4b_idle_tmo",  32'(bus.tmo),  0);

      // Asynchronous reset during WAIT with pending=5
      bus.ev_in = 1'b1; tick;
      bus.ev_in = 1'b0; tick;
      bus.ev_in = 1'b1; repeat (5) tick;
      bus.ev_in = 1'b0;
      chk("s5_pend5", 32'(bus.pending), 5);
      chk("s5_busy",  32'(bus.busy),    1);
      rst = 1'b0;
      #2;
      chk("s5_async_pend", 32'(bus.pending), 0);
      chk("s5_async_busy", 32'(bus.busy),    0);
      tick;
      chk("s5_rst_req",  32'(bus.req_out), 0);
      chk("s5_rst_busy", 32'(bus.busy),    0);
      chk("s5_rst_pend", 32'(bus.pending), 0);
      rst = 1'b1;
      bus.ev_in = 1'b1; tick;
      chk("s5_k_pend", 32'(bus.pending), 1);
      chk("s5_k_req",  32'(bus.req_out), 0);
      bus.ev_in = 1'b0; tick;
      chk("s5_k1_req", 32'(bus.req_out), 1);
      tick;
      chk("s5_k2_req", 32'(bus.req_out), 0);

      do_reset;

      // Six events during WAIT, then ack
      bus.ev_in = 1'b1; tick;
      bus.ev_in = 1'b0; tick;
      chk("s6_req", 32'(bus.req_out), 1);
      bus.ev_in = 1'b1; repeat (6) tick;
      bus.ev_in = 1'b0;
      chk("s6_pend6", 32'(bus.pending), 6);
      bus.ack_in = 1'b1; tick;
      bus.ack_in = 1'b0; tick;
      chk("s6_idle_busy", 32'(bus.busy), 0);
      tick;
      chk("s6_reissue_req", 32'(bus.req_out), 1);
`ifdef REQ_PACER_COALESCE_EN
      chk("s6_pend_after_issue", 32'(bus.pending), 0);
`else
      chk("s6_pend_after_issue", 32'(bus.pending), 5);
`endif
      cnt = 0;
      for (int t = 12; t <= 25; t++) begin
         bus.ack_in = (t == 13);
         tick;
         if (bus.req_out) cnt++;
      end
      bus.ack_in = 1'b0;
`ifdef REQ_PACER_COALESCE_EN
      chk("s6_later_reqs", 32'(cnt), 0);
`else
      chk("s6_later_reqs", 32'(cnt), 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
